// File: rtl/core_pkg.sv
// Shared types for the RV64I decode stage: format codes, opcode map and the
// decoded-instruction record carried through the output and skid registers.
package core_pkg;

    localparam int CORE_XLEN = 64;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [4:0]           rd;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [CORE_XLEN-1:0] imm;
        logic [2:0]           funct3;
        logic [6:0]           funct7;
        logic [6:0]           opcode;
        fmt_e                 format;
        logic                 illegal;
        logic [CORE_XLEN-1:0] pc;
    } dec_t;

    function automatic logic [CORE_XLEN-1:0] sext32(input logic [31:0] v);
        return {{(CORE_XLEN-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/core_decode_fields.sv
// Combinational field extraction: raw instruction word + PC -> decoded record.
module core_decode_fields
    import core_pkg::*;
(
    input  logic [31:0]          instr,
    input  logic [CORE_XLEN-1:0] pc,
    output dec_t                 dec
);

    logic is_shift;
    assign is_shift = (instr[13:12] == 2'b01);

    always_comb begin
        dec         = '0;
        dec.rd      = instr[11:7];
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.funct3  = instr[14:12];
        dec.opcode  = instr[6:0];
        dec.pc      = pc;
        dec.format  = FMT_ILL;
        dec.illegal = 1'b0;
        dec.imm     = '0;
        dec.funct7  = '0;
        case (instr[6:0])
            OP_OP, OP_OP32: begin
                dec.format = FMT_R;
                dec.funct7 = instr[31:25];
            end
            // Shift amounts are zero-extended and the funct7 LSB is cleared on
            // RV64 shifts so funct7==0 always means logical shift downstream.
            OP_IMM: begin
                dec.format = FMT_I;
                if (is_shift) begin
                    dec.imm    = CORE_XLEN'(instr[25:20]);
                    dec.funct7 = {instr[31:26], 1'b0};
                end else begin
                    dec.imm = sext32({{20{instr[31]}}, instr[31:20]});
                end
            end
            OP_IMM32: begin
                dec.format = FMT_I;
                if (is_shift) begin
                    dec.imm    = CORE_XLEN'(instr[24:20]);
                    dec.funct7 = instr[31:25];
                end else begin
                    dec.imm = sext32({{20{instr[31]}}, instr[31:20]});
                end
            end
            OP_LOAD, OP_JALR, OP_SYSTEM: begin
                dec.format = FMT_I;
                dec.imm    = sext32({{20{instr[31]}}, instr[31:20]});
            end
            OP_STORE: begin
                dec.format = FMT_S;
                dec.imm    = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
            end
            OP_BRANCH: begin
                dec.format = FMT_B;
                dec.imm    = sext32({{19{instr[31]}}, instr[31], instr[7],
                                     instr[30:25], instr[11:8], 1'b0});
            end
            OP_LUI, OP_AUIPC: begin
                dec.format = FMT_U;
                dec.imm    = sext32({instr[31:12], 12'b0});
            end
            OP_JAL: begin
                dec.format = FMT_J;
                dec.imm    = sext32({{11{instr[31]}}, instr[31], instr[19:12],
                                     instr[20], instr[30:21], 1'b0});
            end
            default: begin
                dec.format  = FMT_ILL;
                dec.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/core_decode_stage.sv
// RV64I decode stage: decode at the input, output register plus one skid entry
// so in_ready is a registered function of skid occupancy only.
module core_decode_stage
    import core_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       funct3,
    output logic [6:0]       funct7,
    output logic [6:0]       opcode,
    output logic [2:0]       format,
    output logic             illegal,
    output logic [XLEN-1:0]  pc,
    output logic [CNT_W-1:0] decode_count
);

    dec_t             dec, out_q, skid_q;
    logic             out_v, skid_v;
    logic [CNT_W-1:0] cnt_q;
    logic             acc, drain;

    core_decode_fields u_fields (
        .instr (in_instr),
        .pc    (CORE_XLEN'(in_pc)),
        .dec   (dec)
    );

    assign in_ready = !skid_v;
    assign acc      = in_valid && !skid_v;
    assign drain    = out_v && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            skid_q <= '0;
            out_v  <= 1'b0;
            skid_v <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (drain)
                cnt_q <= cnt_q + CNT_W'(1);
            // Flush wins over any accept; the handshake above still counts.
            if (flush) begin
                out_v  <= 1'b0;
                skid_v <= 1'b0;
            end else if (!out_v || drain) begin
                // Skid is only ever full while the output is, and accept is
                // blocked while skid is full, so the two cases are exclusive.
                if (skid_v) begin
                    out_q  <= skid_q;
                    out_v  <= 1'b1;
                    skid_v <= 1'b0;
                end else if (acc) begin
                    out_q <= dec;
                    out_v <= 1'b1;
                end else begin
                    out_v <= 1'b0;
                end
            end else if (acc) begin
                skid_q <= dec;
                skid_v <= 1'b1;
            end
        end
    end

    assign out_valid    = out_v;
    assign rd           = out_q.rd;
    assign rs1          = out_q.rs1;
    assign rs2          = out_q.rs2;
    assign imm          = XLEN'(out_q.imm);
    assign funct3       = out_q.funct3;
    assign funct7       = out_q.funct7;
    assign opcode       = out_q.opcode;
    assign format       = out_q.format;
    assign illegal      = out_q.illegal;
    assign pc           = XLEN'(out_q.pc);
    assign decode_count = cnt_q;

endmodule

// File: doc/core_decode_stage.md
# core_decode_stage

Pipelined RV64I decode stage between instruction fetch and `core_execute_unit`. It accepts 32-bit instruction words over a valid/ready handshake, splits them into register indices, sign-extended immediate, funct fields, opcode and format code, and holds the result in an output register. A 2-entry skid buffer absorbs execute back-pressure without a combinational ready path from output to input. It also flags illegal encodings and counts retired decodes.

## Interface
- `XLEN`, 64: immediate/PC width.
- `CNT_W`, 32: width of decode counter.
---
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  discard all buffered/output instructions.
- `in_valid`  in  1  fetch presents instruction.
- `in_ready`  out  1  stage can accept.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  XLEN  instruction address.
- `out_valid`  out  1  decoded instruction present.
- `out_ready`  in  1  execute consumes.
- `rd`, `rs1`, `rs2`  out  5 each  register indices.
- `imm`  out  XLEN  sign-extended immediate.
- `funct3`  out  3; `funct7`  out  7; `opcode`  out  7.
- `format`  out  3  R=0, I=1, S=2, B=3, U=4, J=5, illegal=7.
- `illegal`  out  1  unrecognised opcode.
- `pc`  out  XLEN  PC of the output instruction.
- `decode_count`  out  CNT_W  output handshakes since reset.

## Operation
- Format map: 0110011, 0111011 → R; 0010011, 0011011, 0000011, 1100111, 1110011 → I; 0100011 → S; 1100011 → B; 0110111, 0010111 → U; 1101111 → J; anything else → format 7, `illegal`=1, all other fields still driven from raw bits.
- Immediates per RV spec, sign-extended from bit 31 to XLEN; U-type `imm` = {sext(instr[31:12]), 12'b0}.
- `funct7` = instr[31:25] for R-type and for I-type shifts; 0 otherwise.
- Shift-immediates, funct3 001/101: opcode 0010011 → `imm` = zero-extended instr[25:20], `funct7` = {instr[31:26],1'b0}; opcode 0011011 → `imm` = zero-extended instr[24:20], `funct7` = instr[31:25]. Guarantees `funct7`==0 selects logical shift downstream even when shamt[5]=1.
- Buffering: output register plus one skid entry. `in_ready` = skid entry empty (registered). Input accepted when `in_valid && in_ready`. Decoded into output reg if empty or draining this cycle, else into skid. On output handshake with skid full, skid moves to output.
- Strict in-order; no drop, no duplication.
- `decode_count` increments on `out_valid && out_ready`, wraps at 2^CNT_W.
- `flush`: next cycle `out_valid`=0, skid empty, `in_ready`=1. Flush beats a simultaneous accept (input dropped). An output handshake in the flush cycle still counts.

## Timing
- Latency: accepted at edge N → `out_valid` from N+1, with the instruction's fields.
- Throughput 1/cycle with `out_ready` held high.
- `out_valid` stays high and fields stay stable until handshake.
- `in_ready` has no combinational dependence on `out_ready` or `in_valid`.
- Reset: `out_valid`=0, `in_ready`=1 the cycle after reset deasserts, all field outputs 0, `format`=0, `illegal`=0, `decode_count`=0. Reset during a stall discards everything.
- Full: output and skid occupied → `in_ready`=0; it reasserts the cycle after the first output handshake.

## Structure
- `core_pkg`: format enum (FMT_R … FMT_J, FMT_ILL=7), opcode localparams, decoded-instruction packed struct (rd, rs1, rs2, imm, funct3, funct7, opcode, format, illegal, pc).
- Sub-module `core_decode_fields`: purely combinational instr/pc → struct. The stage instantiates it once, at the input, and registers the struct in the output and skid entries.

## Test plan
- 0xFFF00093 (ADDI x1,x0,-1), out_ready=1 → next cycle rd=1, rs1=0, imm=0xFFFF_FFFF_FFFF_FFFF, funct3=0, opcode=0x13, format=1, funct7=0.
- 0x4210D113 (SRAI x2,x1,33) → rd=2, rs1=1, funct3=5, funct7=0x20, imm=33; 0x0210D113 (SRLI x2,x1,33) → funct7=0x00, imm=33.
- Three back-to-back instructions with out_ready=0 for 3 cycles → `in_ready` low after the 2nd is accepted; the 3rd is held at fetch; on release all three emerge in order, `decode_count`=3.
- 0x00000000 → format=7, illegal=1, handshake completes, count increments.
- Output and skid full, `flush`=1 with `in_valid`=1 → next cycle out_valid=0, in_ready=1, the presented instruction is not emitted.
- `rst` asserted mid-stall → all outputs at reset values next cycle, `decode_count`=0.
